conv_window_gen: RTL

- Sliding-window generator that feeds the convolution filter banks.
- Accepts a raster-order pixel stream (all N1 input channels per beat) and produces every valid FN x FN window, flattened onto one bus.
- Output bus maps directly onto the filter's x<k>_<j>_<i> inputs.
- No padding: only fully interior windows are emitted. Stride 1.

---
 rtl/conv_window_gen_if.sv | 37 +++
 rtl/conv_window_gen.sv | 172 +++++++++++++++++
 2 files changed

// File: rtl/conv_window_gen_if.sv
`default_nettype none
// ============================================================================
//  Module   : conv_window_gen_if
//  Purpose  : Stream bundle for the sliding-window generator. Carries the
//             raster pixel input handshake and the flattened window output
//             handshake.
//  Ports    : in_valid/in_ready/in_pix    - pixel beat (N1 channels)
//             out_valid/out_ready/out_win - FN x FN x N1 window
//             out_last                    - final window of the frame
//  Modports : slave  - the window generator
//             master - the producer/consumer environment around it
//  Revision : 1.0 - initial release
// ============================================================================
interface conv_window_gen_if #(
    parameter int WIDTH = 8,
    parameter int FN    = 3,
    parameter int N1    = 1
);
    logic                         in_valid;
    logic                         in_ready;
    logic [N1*WIDTH-1:0]          in_pix;
    logic                         out_valid;
    logic                         out_ready;
    logic [FN*FN*N1*WIDTH-1:0]    out_win;
    logic                         out_last;

    modport slave (
        input  in_valid, in_pix, out_ready,
        output in_ready, out_valid, out_win, out_last
    );

    modport master (
        output in_valid, in_pix, out_ready,
        input  in_ready, out_valid, out_win, out_last
    );
endinterface
`default_nettype wire

// File: rtl/conv_window_gen.sv
`default_nettype none
// ============================================================================
//  Module   : conv_window_gen
//  Purpose  : Sliding-window generator for the convolution filter banks.
//             Takes a raster-order pixel stream (all N1 channels per beat)
//             and emits every fully interior FN x FN window, stride 1,
//             flattened so that sample x<k>_<j>_<i> sits at bit offset
//             ((k*FN+i)*FN+j)*WIDTH.
//  Ports    : clk    - clock
//             resetn - asynchronous active-low reset
//             flush  - synchronous abort of the current frame
//             bus    - conv_window_gen_if.slave (pixel in / window out)
//  Revision : 1.0 - initial release
// ============================================================================
module conv_window_gen #(
    parameter int WIDTH = 8,
    parameter int FN    = 3,
    parameter int N1    = 1,
    parameter int IMG_W = 28,
    parameter int IMG_H = 28
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              flush,
    conv_window_gen_if.slave  bus
);

    localparam int C_PIX_W = N1 * WIDTH;
    localparam int C_WIN_W = FN * FN * C_PIX_W;
    localparam int C_COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int C_ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [C_COL_W-1:0] C_COL_LAST = C_COL_W'(IMG_W - 1);
    localparam logic [C_ROW_W-1:0] C_ROW_LAST = C_ROW_W'(IMG_H - 1);
    localparam logic [C_COL_W-1:0] C_COL_EDGE = C_COL_W'(FN - 1);
    localparam logic [C_ROW_W-1:0] C_ROW_EDGE = C_ROW_W'(FN - 1);

    // Position of the next pixel to be accepted
    logic [C_COL_W-1:0] r_col;
    logic [C_ROW_W-1:0] r_row;

    // Output stage
    logic               r_out_valid;
    logic               r_out_last;
    logic [C_WIN_W-1:0] r_out_win;

    // Window register, indexed [i = vertical][j = horizontal]
    logic [C_PIX_W-1:0] r_win     [FN][FN];
    logic [C_PIX_W-1:0] w_win_nxt [FN][FN];
    logic [C_WIN_W-1:0] w_win_flat;

    // Line-buffer read data; w_lb_rd[m] is the pixel m+1 rows above
    logic [C_PIX_W-1:0] w_lb_rd [FN-1];

    logic w_in_ready;
    logic w_accept;
    logic w_col_wrap;
    logic w_row_wrap;
    logic w_emit;

    assign w_in_ready = !r_out_valid | bus.out_ready;
    // A beat presented alongside flush is dropped
    assign w_accept   = bus.in_valid & w_in_ready & !flush;
    assign w_col_wrap = (r_col == C_COL_LAST);
    assign w_row_wrap = (r_row == C_ROW_LAST);
    assign w_emit     = w_accept & (r_row >= C_ROW_EDGE) & (r_col >= C_COL_EDGE);

    // ------------------------------------------------------------------------
    // Cascaded line buffers: each read returns the pixel from the row above
    // at the same column, and that same slot is then overwritten, so data
    // ripples one row deeper per buffer.
    // ------------------------------------------------------------------------
    for (genvar m = 0; m < FN - 1; m++) begin : g_lb
        logic [C_PIX_W-1:0] r_mem [IMG_W];
        logic [C_PIX_W-1:0] w_wr;

        if (m == 0) begin : g_head
            assign w_wr = bus.in_pix;
        end else begin : g_tail
            assign w_wr = w_lb_rd[m-1];
        end

        assign w_lb_rd[m] = r_mem[r_col];

        always_ff @(posedge clk) begin
            if (w_accept) begin
                r_mem[r_col] <= w_wr;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next window: shift columns toward j=0, load the new column at j=FN-1.
    // The oldest line buffer supplies the top row (i=0).
    // ------------------------------------------------------------------------
    always_comb begin
        w_win_nxt = r_win;
        for (int i = 0; i < FN; i++) begin
            for (int j = 0; j < FN - 1; j++) begin
                w_win_nxt[i][j] = r_win[i][j+1];
            end
        end
        for (int i = 0; i < FN - 1; i++) begin
            w_win_nxt[i][FN-1] = w_lb_rd[FN-2-i];
        end
        w_win_nxt[FN-1][FN-1] = bus.in_pix;
    end

    always_comb begin
        w_win_flat = '0;
        for (int k = 0; k < N1; k++) begin
            for (int i = 0; i < FN; i++) begin
                for (int j = 0; j < FN; j++) begin
                    w_win_flat[((k*FN+i)*FN+j)*WIDTH +: WIDTH] =
                        w_win_nxt[i][j][k*WIDTH +: WIDTH];
                end
            end
        end
    end

    // Window contents need no reset: partial windows at a row start are
    // never emitted, so stale columns are always shifted out first.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_win <= w_win_nxt;
        end
    end

    // ------------------------------------------------------------------------
    // Position counters and output stage
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_col       <= '0;
            r_row       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
            r_out_win   <= '0;
        end else if (flush) begin
            r_col       <= '0;
            r_row       <= '0;
            r_out_valid <= 1'b0;
            r_out_last  <= 1'b0;
        end else begin
            if (w_accept) begin
                if (w_col_wrap) begin
                    r_col <= '0;
                    r_row <= w_row_wrap ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
            // A new window replaces the old one in the same cycle it is
            // consumed, keeping valid high without a bubble.
            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_last  <= w_col_wrap & w_row_wrap;
                r_out_win   <= w_win_flat;
            end else if (bus.out_ready) begin
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_last  = r_out_last;
    assign bus.out_win   = r_out_win;

endmodule
`default_nettype wire
